requant_engine: RTL and testbench

Requantizes a vector of signed 32-bit accumulator results (as produced by the dense layer engine) back into the packed activation formats the dense engine consumes: signed int8, signed int4, or binary. It sits between consecutive dense layers, taking the previous layer's `out` vector plus a per-layer fixed-point scale and producing the next layer's `in8`/`in4`/`inb` vectors. It uses the same start/done handshake as the dense engine and processes one element per cycle through a 2-stage pipeline.

---
 rtl/requant_engine.sv | 171 +++++++++++++++++
 tb/tb_requant_engine.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_engine.sv
`default_nettype none
// ============================================================================
//  Module   : requant_engine
//  Purpose  : Rescales a signed 32-bit accumulator vector into packed int8,
//             int4 or binary activations. Processes one element per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module requant_engine #(
    parameter int DIM   = 16,
    parameter int CNT_W = $clog2(DIM + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           prec,
    input  logic [32*DIM-1:0]    acc_in,
    input  logic [15:0]          mult,
    input  logic [4:0]           shift,
    output logic [8*DIM-1:0]     out8,
    output logic [4*DIM-1:0]     out4,
    output logic [DIM-1:0]       outb,
    output logic [CNT_W-1:0]     sat_cnt,
    output logic                 busy,
    output logic                 done
);

    localparam int c_idx_w = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(DIM - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [32*DIM-1:0]      r_acc;
    logic [15:0]            r_mult;
    logic [4:0]             r_shift;
    logic [1:0]             r_prec;
    logic [c_idx_w-1:0]     r_idx;

    logic                   r_s1_vld;
    logic signed [48:0]     r_s1_p;
    logic [c_idx_w-1:0]     r_s1_idx;
    logic                   r_s1_pos;

    logic [8*DIM-1:0]       r_out8;
    logic [4*DIM-1:0]       r_out4;
    logic [DIM-1:0]         r_outb;
    logic [CNT_W-1:0]       r_sat_cnt;
    logic                   r_busy;
    logic                   r_done;

    logic [31:0]            w_acc;
    logic signed [48:0]     w_prod;
    logic signed [49:0]     w_rnd;
    logic signed [49:0]     w_sum;
    logic signed [49:0]     w_r;
    logic                   w_ovf8;
    logic                   w_ovf4;
    logic [7:0]             w_q8;
    logic [3:0]             w_q4;
    logic                   w_is_int4;
    logic                   w_is_bin;
    logic                   w_sat;

    // Stage 1: multiplier is zero-extended so the 16-bit scale stays unsigned.
    assign w_acc  = r_acc[r_idx*32 +: 32];
    assign w_prod = $signed({{17{w_acc[31]}}, w_acc}) * $signed({33'd0, r_mult});

    // Stage 2: one extra bit of headroom keeps the rounding add from wrapping.
    assign w_rnd  = (r_shift == 5'd0) ? 50'sd0 : (50'sd1 <<< (r_shift - 5'd1));
    assign w_sum  = $signed({r_s1_p[48], r_s1_p}) + w_rnd;
    assign w_r    = w_sum >>> r_shift;

    assign w_ovf8 = (w_r > 50'sd127) || (w_r < -50'sd128);
    assign w_ovf4 = (w_r > 50'sd7)   || (w_r < -50'sd8);
    assign w_q8   = w_ovf8 ? (w_r[49] ? 8'h80 : 8'h7F) : w_r[7:0];
    assign w_q4   = w_ovf4 ? (w_r[49] ? 4'h8 : 4'h7)   : w_r[3:0];

    // Reserved encoding 2'b11 falls through to int8.
    assign w_is_int4 = (r_prec == 2'b01);
    assign w_is_bin  = (r_prec == 2'b10);
    assign w_sat     = w_is_bin ? 1'b0 : (w_is_int4 ? w_ovf4 : w_ovf8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_mult    <= '0;
            r_shift   <= '0;
            r_prec    <= '0;
            r_idx     <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_p    <= '0;
            r_s1_idx  <= '0;
            r_s1_pos  <= 1'b0;
            r_out8    <= '0;
            r_out4    <= '0;
            r_outb    <= '0;
            r_sat_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc     <= acc_in;
                        r_mult    <= mult;
                        r_shift   <= shift;
                        r_prec    <= prec;
                        r_idx     <= '0;
                        r_out8    <= '0;
                        r_out4    <= '0;
                        r_outb    <= '0;
                        r_sat_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_s1_vld <= 1'b1;
                    r_s1_p   <= w_prod;
                    r_s1_idx <= r_idx;
                    r_s1_pos <= ~w_acc[31];
                    if (r_idx == c_last) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_idx <= r_idx + c_idx_w'(1);
                    end
                end
                S_DRAIN: begin
                    r_s1_vld <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Stage-1 valid is only ever set in RUN/DRAIN, so this never races the IDLE clear.
            if (r_s1_vld) begin
                if (w_is_bin) begin
                    r_outb[r_s1_idx] <= r_s1_pos;
                end else if (w_is_int4) begin
                    r_out4[r_s1_idx*4 +: 4] <= w_q4;
                end else begin
                    r_out8[r_s1_idx*8 +: 8] <= w_q8;
                end
                if (w_sat) begin
                    r_sat_cnt <= r_sat_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign out8    = r_out8;
    assign out4    = r_out4;
    assign outb    = r_outb;
    assign sat_cnt = r_sat_cnt;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_requant_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_requant_engine
//  Purpose  : Directed self-checking bench for requant_engine (DIM=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_requant_engine;

    localparam int DIM   = 4;
    localparam int CNT_W = $clog2(DIM + 1);

    logic                clk;
    logic                rst;
    logic                start;
    logic [1:0]          prec;
    logic [32*DIM-1:0]   acc_in;
    logic [15:0]         mult;
    logic [4:0]          shift;
    logic [8*DIM-1:0]    out8;
    logic [4*DIM-1:0]    out4;
    logic [DIM-1:0]      outb;
    logic [CNT_W-1:0]    sat_cnt;
    logic                busy;
    logic                done;

    int checks;
    int errors;

    requant_engine #(.DIM(DIM), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .prec    (prec),
        .acc_in  (acc_in),
        .mult    (mult),
        .shift   (shift),
        .out8    (out8),
        .out4    (out4),
        .outb    (outb),
        .sat_cnt (sat_cnt),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32*DIM-1:0] pack4(input logic [31:0] a0, input logic [31:0] a1,
                                                input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Starts a run (cycle 0), scrambles inputs after acceptance, waits for done.
    task automatic run_vec(input logic [1:0] p, input logic [15:0] m, input logic [4:0] s,
                           input logic [32*DIM-1:0] a, output int dc);
        int cyc;
        next_cycle();
        prec = p; mult = m; shift = s; acc_in = a; start = 1'b1;
        cyc = 0;
        next_cycle();
        cyc = 1;
        start = 1'b0;
        acc_in = {4{32'h5A5A_1234}}; mult = 16'hFFFF; shift = 5'd1; prec = ~p;
        while (!done && cyc < 40) begin
            next_cycle();
            cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: done not seen after %0d cycles", cyc);
        end
        dc = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; prec = 2'b00; acc_in = '0; mult = '0; shift = '0;
        repeat (3) next_cycle();
        checks++;
        if ({out8, out4, outb, sat_cnt, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_state: out8=%h out4=%h outb=%b sat=%0d busy=%b done=%b, required all 0",
                     out8, out4, outb, sat_cnt, busy, done);
        end
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_int8_round();
        int dc;
        int c_busy_bad;
        c_busy_bad = 0;
        next_cycle();
        prec = 2'b00; mult = 16'd1; shift = 5'd3;
        acc_in = pack4(32'd1000, -32'sd1000, 32'd50, 32'd0);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        dc = 1;
        while (!done && dc < 40) begin
            if (busy !== 1'b1) c_busy_bad++;
            next_cycle();
            dc++;
        end
        checks++;
        if (dc !== 6 || busy !== 1'b0) begin
            errors++;
            $display("FAIL int8_done_cycle: done at cycle %0d busy=%b, required cycle 6 busy=0", dc, busy);
        end
        checks++;
        if (c_busy_bad !== 0) begin
            errors++;
            $display("FAIL int8_busy: busy low in %0d of cycles 1..5, required 0", c_busy_bad);
        end
        checks++;
        if (out8 !== 32'h0006_837D || sat_cnt !== 3'd0) begin
            errors++;
            $display("FAIL int8_round: out8=%h sat=%0d, required 0006837d sat=0", out8, sat_cnt);
        end
        checks++;
        if (out4 !== '0 || outb !== '0) begin
            errors++;
            $display("FAIL int8_other_fields: out4=%h outb=%b, required 0", out4, outb);
        end
        next_cycle();
        checks++;
        if (done !== 1'b0 || out8 !== 32'h0006_837D) begin
            errors++;
            $display("FAIL done_pulse: done=%b out8=%h, required done=0 out8 held 0006837d", done, out8);
        end
    endtask

    task automatic test_int8_saturation();
        int dc;
        run_vec(2'b00, 16'd1, 5'd3, pack4(32'd2000, -32'sd2000, 32'd1023, -32'sd1028), dc);
        checks++;
        if (out8 !== 32'h807F_807F || sat_cnt !== 3'd3) begin
            errors++;
            $display("FAIL int8_sat: out8=%h sat=%0d, required 807f807f sat=3", out8, sat_cnt);
        end
    endtask

    task automatic test_int4();
        int dc;
        run_vec(2'b01, 16'd1, 5'd3, pack4(32'd56, -32'sd60, 32'd7, 32'd100), dc);
        checks++;
        if (out4 !== 16'h7197 || sat_cnt !== 3'd1 || out8 !== '0 || outb !== '0) begin
            errors++;
            $display("FAIL int4: out4=%h sat=%0d out8=%h outb=%b, required 7197 sat=1 others 0",
                     out4, sat_cnt, out8, outb);
        end
    endtask

    task automatic test_binary();
        int dc;
        run_vec(2'b10, 16'd5, 5'd2, pack4(32'd5, -32'sd1, 32'd0, -32'sd7), dc);
        checks++;
        if (outb !== 4'b0101 || sat_cnt !== 3'd0 || out8 !== '0 || out4 !== '0) begin
            errors++;
            $display("FAIL binary: outb=%b sat=%0d out8=%h out4=%h, required 0101 sat=0 others 0",
                     outb, sat_cnt, out8, out4);
        end
    endtask

    task automatic test_unscaled_and_edges();
        int dc;
        run_vec(2'b00, 16'd3, 5'd0, pack4(32'd40, -32'sd40, 32'd42, -32'sd43), dc);
        checks++;
        if (out8 !== 32'h807E_8878 || sat_cnt !== 3'd1) begin
            errors++;
            $display("FAIL shift0: out8=%h sat=%0d, required 807e8878 sat=1", out8, sat_cnt);
        end
        run_vec(2'b00, 16'd0, 5'd3, pack4(32'd100000, -32'sd100000, 32'd7, -32'sd9), dc);
        checks++;
        if (out8 !== '0 || sat_cnt !== 3'd0) begin
            errors++;
            $display("FAIL mult0: out8=%h sat=%0d, required 0 sat=0", out8, sat_cnt);
        end
        run_vec(2'b11, 16'd1, 5'd3, pack4(32'd1000, -32'sd1000, 32'd50, 32'd0), dc);
        checks++;
        if (out8 !== 32'h0006_837D || out4 !== '0 || outb !== '0) begin
            errors++;
            $display("FAIL prec_reserved: out8=%h out4=%h outb=%b, required 0006837d 0 0", out8, out4, outb);
        end
        run_vec(2'b00, 16'hFFFF, 5'd31, pack4(32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd16385), dc);
        checks++;
        if (out8 !== 32'h0100_807F || sat_cnt !== 3'd2) begin
            errors++;
            $display("FAIL shift31: out8=%h sat=%0d, required 0100807f sat=2", out8, sat_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        next_cycle();
        prec = 2'b00; mult = 16'd1; shift = 5'd3;
        acc_in = pack4(32'd1000, -32'sd1000, 32'd50, 32'd0);
        start = 1'b1;
        next_cycle();
        // start stays high with a different vector through cycle 7
        acc_in = pack4(32'd2000, -32'sd2000, 32'd1023, -32'sd1028);
        for (cyc = 1; cyc < 6; cyc++) next_cycle();
        checks++;
        if (done !== 1'b1 || out8 !== 32'h0006_837D || sat_cnt !== 3'd0) begin
            errors++;
            $display("FAIL b2b_ignore: done=%b out8=%h sat=%0d, required done=1 0006837d sat=0",
                     done, out8, sat_cnt);
        end
        next_cycle();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out8 !== 32'h0006_837D) begin
            errors++;
            $display("FAIL b2b_cycle7: busy=%b done=%b out8=%h, required 0 0 0006837d", busy, done, out8);
        end
        next_cycle();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || out8 !== '0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b out8=%h in cycle 8, required busy=1 out8=0", busy, out8);
        end
        cyc = 8;
        while (!done && cyc < 40) begin
            next_cycle();
            cyc++;
        end
        checks++;
        if (cyc !== 13 || out8 !== 32'h807F_807F || sat_cnt !== 3'd3) begin
            errors++;
            $display("FAIL b2b_second: done cycle %0d out8=%h sat=%0d, required 13 807f807f 3",
                     cyc, out8, sat_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        int dc;
        int seen_done;
        seen_done = 0;
        next_cycle();
        prec = 2'b00; mult = 16'd1; shift = 5'd3;
        acc_in = pack4(32'd1000, -32'sd1000, 32'd50, 32'd0);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        checks++;
        if (out8[7:0] !== 8'h7D) begin
            errors++;
            $display("FAIL midrun_partial: out8[0]=%h in cycle 3, required 7d", out8[7:0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out8, out4, outb, sat_cnt, busy, done} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: out8=%h sat=%0d busy=%b done=%b, required all 0",
                     out8, sat_cnt, busy, done);
        end
        repeat (2) next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) seen_done++;
            next_cycle();
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL midrun_no_done: done seen %0d times after abort, required 0", seen_done);
        end
        run_vec(2'b01, 16'd1, 5'd3, pack4(32'd56, -32'sd60, 32'd7, 32'd100), dc);
        checks++;
        if (dc !== 6 || out4 !== 16'h7197 || sat_cnt !== 3'd1) begin
            errors++;
            $display("FAIL midrun_recover: done cycle %0d out4=%h sat=%0d, required 6 7197 1",
                     dc, out4, sat_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_int8_round();
        test_int8_saturation();
        test_int4();
        test_binary();
        test_unscaled_and_edges();
        test_back_to_back();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
